cb_exec: RTL and testbench

Sequencer for CB-prefixed bit/rotate/shift instructions, sitting directly upstream of the ALU. It accepts a latched CB opcode from the decoder and fetches the operand from the register file or from memory at (HL). It presents the operand and the bit index to the ALU, then writes the result and the flag updates back (no result write for BIT). It owns all multi-cycle handshaking, so the ALU stays purely combinational.

---
 rtl/cb_exec.sv | 173 +++++++++++++++++
 tb/tb_cb_exec.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_exec.sv
// cb_exec: sequencer for CB-prefixed bit/rotate/shift instructions.
// Fetches the operand from the register file or from (HL), presents it to a
// purely combinational ALU, then writes back the result and flag updates.
//
// Ports:
//   clk, nreset            clock, synchronous active-low reset
//   start, opcode, flags_c instruction request, CB opcode, carry-in
//   busy, done, illegal    status; done/illegal are one-cycle pulses
//   reg_rsel/reg_rdata     register-file read
//   reg_we/wsel/wdata      register-file write
//   mem_rd/wr/wdata/rdata/ack  (HL) memory handshake
//   alu_op/a/cin, alu_res/flags  ALU interface
//   flags_we, flags_out    per-flag write-back {Z,N,H,C}
//
// Build option: define CB_EXEC_HL_EN to support the (HL) operand. Without it
// an (HL) opcode completes immediately with illegal set and no strobes.
module cb_exec (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] opcode,
    input  logic       flags_c,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic [2:0] reg_rsel,
    input  logic [7:0] reg_rdata,
    output logic       reg_we,
    output logic [2:0] reg_wsel,
    output logic [7:0] reg_wdata,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [7:0] alu_op,
    output logic [7:0] alu_a,
    output logic       alu_cin,
    input  logic [7:0] alu_res,
    input  logic [3:0] alu_flags,
    output logic [3:0] flags_we
    ,
    output logic [3:0] flags_out
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLAG_W = 4;
    localparam logic [2:0]  OPND_HL = 3'd6;
    localparam logic [1:0]  GRP_ROT = 2'b00;
    localparam logic [1:0]  GRP_BIT = 2'b01;

    typedef enum logic [2:0] {IDLE, RD, MRD, EX, MWR, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   op_q, opnd_q;
    logic                cin_q;
    logic                busy_q, done_q, illegal_q, reg_we_q;
    logic [FLAG_W-1:0]   flags_we_q;
    logic                illegal_d, reg_we_d;
    logic [FLAG_W-1:0]   flags_we_d;
    logic                op_hl, op_bit, op_rot, start_hl, in_ex;

    assign op_hl    = (op_q[2:0] == OPND_HL);
    assign op_bit   = (op_q[7:6] == GRP_BIT);
    assign op_rot   = (op_q[7:6] == GRP_ROT);
    assign start_hl = (opcode[2:0] == OPND_HL);
    assign in_ex    = (state_q == EX);

    // Next state plus the strobes that go with it; strobes are registered so
    // they are computed from state_d for the cycle after the edge.
    always_comb begin
        state_d    = state_q;
        illegal_d  = 1'b0;
        reg_we_d   = 1'b0;
        flags_we_d = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_hl) begin
`ifdef CB_EXEC_HL_EN
                        state_d   = MRD;
`else
                        state_d   = DONE;
                        illegal_d = 1'b1;
`endif
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = EX;
            MRD:     if (mem_ack) state_d = EX;
            EX:      state_d = (op_hl && !op_bit) ? MWR : DONE;
            MWR:     if (mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // op_q is already latched whenever EX is about to be entered
        if (state_d == EX) begin
            reg_we_d = !op_hl && !op_bit;
            if (op_rot)      flags_we_d = 4'b1111;
            else if (op_bit) flags_we_d = 4'b1110;
        end
    end

    // State, instruction/operand latches and registered strobes
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            opnd_q     <= '0;
            cin_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            flags_we_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
            illegal_q  <= illegal_d;
            reg_we_q   <= reg_we_d;
            flags_we_q <= flags_we_d;
            if (state_q == IDLE && start) begin
                op_q  <= opcode;
                cin_q <= flags_c;
            end
            if (state_q == RD)            opnd_q <= reg_rdata;
            if (state_q == MRD && mem_ack) opnd_q <= mem_rdata;
        end
    end

`ifdef CB_EXEC_HL_EN
    logic              mem_rd_q, mem_wr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Memory requests held until ack; reset drops any pending request
    always_ff @(posedge clk) begin
        if (!nreset) begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_rd_q <= (state_d == MRD);
            mem_wr_q <= (state_d == MWR);
            if (in_ex && op_hl) mem_wdata_q <= alu_res;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
`else
    assign mem_rd    = 1'b0;
    assign mem_wr    = 1'b0;
    assign mem_wdata = '0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign reg_we    = reg_we_q;
    assign flags_we  = flags_we_q;
    assign reg_rsel  = op_q[2:0];
    assign reg_wsel  = op_q[2:0];
    assign alu_op    = op_q;
    assign alu_a     = opnd_q;
    assign alu_cin   = cin_q;
    // ALU result and flags pass straight through during EX only
    assign reg_wdata = in_ex ? alu_res : DATA_W'(0);
    assign flags_out = in_ex ? alu_flags : FLAG_W'(0);

endmodule

// File: tb/tb_cb_exec.sv
// Bench for cb_exec: register file, (HL) memory with programmable ack delay and
// a reference ALU around the DUT; a scoreboard holds the expected outcome of
// each instruction and is popped when done pulses.
module tb_cb_exec;
    logic       clk = 1'b0;
    logic       nreset, start, flags_c;
    logic [7:0] opcode;
    logic       busy, done, illegal;
    logic [2:0] reg_rsel, reg_wsel;
    logic [7:0] reg_rdata, reg_wdata;
    logic       reg_we, mem_rd, mem_wr, mem_ack;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] alu_op, alu_a, alu_res;
    logic       alu_cin;
    logic [3:0] alu_flags, flags_we, flags_out;

    logic [7:0] regs [8];
    logic [7:0] mem_val;
    int         mem_delay;
    int         waitcnt = 0;
    int         cycle = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    typedef struct {
        logic [7:0] op;
        logic       reg_we;
        logic [2:0] wsel;
        logic [7:0] wdata;
        logic [3:0] fwe;
        logic [3:0] fval;
        int         rd_n;
        int         wr_n;
        logic [7:0] mwdata;
        logic       ill;
        int         ex_k;
        int         done_k;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge clk) waitcnt <= (mem_rd || mem_wr) ? waitcnt + 1 : 0;

    assign mem_ack   = (mem_rd || mem_wr) && (waitcnt >= mem_delay);
    assign mem_rdata = mem_val;
    assign reg_rdata = regs[reg_rsel];

    // Reference ALU: {Z,N,H,C, result}
    function automatic logic [11:0] alu_f(input logic [7:0] op, input logic [7:0] a,
                                          input logic cin);
        logic [7:0] r;
        logic       c, h, z;
        logic [2:0] s;
        s = op[5:3];
        r = a;
        c = cin;
        h = 1'b0;
        case (op[7:6])
            2'b00: case (s)
                3'd0: begin r = {a[6:0], a[7]}; c = a[7]; end
                3'd1: begin r = {a[0], a[7:1]}; c = a[0]; end
                3'd2: begin r = {a[6:0], cin};  c = a[7]; end
                3'd3: begin r = {cin, a[7:1]};  c = a[0]; end
                3'd4: begin r = {a[6:0], 1'b0}; c = a[7]; end
                3'd5: begin r = {a[7], a[7:1]}; c = a[0]; end
                3'd6: begin r = {a[6:0], 1'b1}; c = a[7]; end
                default: begin r = {1'b0, a[7:1]}; c = a[0]; end
            endcase
            2'b01:   h = 1'b1;
            2'b10:   r = a & ~(8'd1 << s);
            default: r = a | (8'd1 << s);
        endcase
        z = (op[7:6] == 2'b01) ? ~a[s] : (r == 8'h00);
        return {z, 1'b0, h, c, r};
    endfunction

    assign {alu_flags, alu_res} = alu_f(alu_op, alu_a, alu_cin);

    cb_exec dut (
        .clk(clk), .nreset(nreset), .start(start), .opcode(opcode), .flags_c(flags_c),
        .busy(busy), .done(done), .illegal(illegal),
        .reg_rsel(reg_rsel), .reg_rdata(reg_rdata),
        .reg_we(reg_we), .reg_wsel(reg_wsel), .reg_wdata(reg_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_op(alu_op), .alu_a(alu_a), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_flags(alu_flags),
        .flags_we(flags_we), .flags_out(flags_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, done, illegal, reg_rsel, reg_we, reg_wsel, reg_wdata,
                    mem_rd, mem_wr, mem_wdata, alu_op, alu_a, alu_cin,
                    flags_we, flags_out});
    endfunction

    // Expected outcome for operand value a, carry-in cin, memory wait d
    function automatic exp_t exp_for(input logic [7:0] op, input logic [7:0] a,
                                     input logic cin, input int d);
        exp_t       e;
        logic [11:0] r;
        logic       bt;
        r      = alu_f(op, a, cin);
        bt     = (op[7:6] == 2'b01);
        e.op   = op;
        e.wsel = op[2:0];
        e.fwe  = (op[7:6] == 2'b00) ? 4'hF : (bt ? 4'hE : 4'h0);
        e.fval = r[11:8] & e.fwe;
        e.ill  = 1'b0;
        if (op[2:0] != 3'd6) begin
            e.reg_we = !bt;
            e.wdata  = bt ? 8'h00 : r[7:0];
            e.rd_n   = 0;
            e.wr_n   = 0;
            e.mwdata = 8'h00;
            e.ex_k   = 2;
            e.done_k = 3;
        end else begin
            e.reg_we = 1'b0;
            e.wdata  = 8'h00;
            e.rd_n   = d + 1;
            e.wr_n   = bt ? 0 : d + 1;
            e.mwdata = bt ? 8'h00 : r[7:0];
            e.done_k = bt ? d + 3 : 2 * d + 4;
            e.ex_k   = (e.fwe != 4'h0) ? d + 2 : -1;
        end
        return e;
    endfunction

    function automatic exp_t exp_ill(input logic [7:0] op);
        exp_t e;
        e = exp_for(op, 8'h00, 1'b0, 0);
        e.fwe = 4'h0; e.fval = 4'h0; e.rd_n = 0; e.wr_n = 0; e.mwdata = 8'h00;
        e.ill = 1'b1; e.ex_k = -1; e.done_k = 1;
        return e;
    endfunction

    // Issue one instruction and compare its observed behaviour at done.
    // poke pulses start again while the instruction is in flight.
    task automatic run(input exp_t e, input logic cin, input bit poke);
        int t0, k, o_rd, o_wr, o_busy, o_ex, o_done;
        logic o_rwe, o_ill, o_ovl, seen;
        logic [2:0] o_ws;
        logic [7:0] o_wd, o_mwd;
        logic [3:0] o_fwe, o_fv;
        exp_t x;
        string p;
        o_rd = 0; o_wr = 0; o_busy = 0; o_ex = -1; o_done = -1;
        o_rwe = 0; o_ill = 0; o_ovl = 0; seen = 0;
        o_ws = '0; o_wd = '0; o_mwd = '0; o_fwe = '0; o_fv = '0;
        x = e;
        @(posedge clk); #1;
        start = 1'b1; opcode = e.op; flags_c = cin;
        sb.push_back(e);
        @(posedge clk); #1;
        t0 = cycle;
        start = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            k = cycle - t0 + 1;
            if (poke) begin
                if (k == 1) begin start = 1'b1; opcode = 8'hC7; end
                else start = 1'b0;
            end
            if (busy) o_busy++;
            if (mem_rd) o_rd++;
            if (mem_wr) begin o_wr++; o_mwd = mem_wdata; end
            if (mem_rd && mem_wr) o_ovl = 1'b1;
            if (reg_we || flags_we != 4'h0) begin
                o_ex = k; o_rwe = reg_we; o_ws = reg_wsel;
                if (reg_we) o_wd = reg_wdata;
                o_fwe = flags_we; o_fv = flags_out & flags_we;
            end
            if (done) begin
                seen = 1'b1; o_done = k; o_ill = illegal;
                x = sb.pop_front();
            end
        end
        p = $sformatf("op%02h ", x.op);
        if (!seen) begin
            x = sb.pop_front();
            chk({p, "timeout"}, 64'(0), 64'(1));
        end
        chk({p, "done_cycle"}, 64'(o_done), 64'(x.done_k));
        chk({p, "illegal"},    64'(o_ill),  64'(x.ill));
        chk({p, "busy_cycles"}, 64'(o_busy), 64'(x.done_k));
        chk({p, "mem_rd_cycles"}, 64'(o_rd), 64'(x.rd_n));
        chk({p, "mem_wr_cycles"}, 64'(o_wr), 64'(x.wr_n));
        chk({p, "mem_wdata"},  64'(o_mwd),  64'(x.mwdata));
        chk({p, "rd_wr_overlap"}, 64'(o_ovl), 64'(0));
        chk({p, "ex_cycle"},   64'(o_ex),   64'(x.ex_k));
        chk({p, "reg_we"},     64'(o_rwe),  64'(x.reg_we));
        chk({p, "reg_wdata"},  64'(o_wd),   64'(x.wdata));
        if (x.reg_we) chk({p, "reg_wsel"}, 64'(o_ws), 64'(x.wsel));
        chk({p, "flags_we"},   64'(o_fwe),  64'(x.fwe));
        chk({p, "flags_out"},  64'(o_fv),   64'(x.fval));
        if (start) @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({p, "idle_after"}, 64'({busy, done, illegal}), 64'(0));
    endtask

    initial begin
        exp_t e;
        logic [7:0] op, v;
        logic c;
        nreset = 1'b0; start = 1'b0; opcode = '0; flags_c = 1'b0;
        mem_val = '0; mem_delay = 0;
        for (int i = 0; i < 8; i++) regs[i] = 8'(i * 17);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 64'(0));
        nreset = 1'b1;

        // BIT 7,A with A=0x7F: Z=1 N=0 H=1
        regs[7] = 8'h7F;
        e = exp_for(8'h7F, 8'h7F, 1'b0, 0); e.fval = 4'b1010;
        run(e, 1'b0, 1'b0);
        // RES 0,B with B=0xFF
        regs[0] = 8'hFF;
        e = exp_for(8'h80, 8'hFF, 1'b0, 0); e.wdata = 8'hFE;
        run(e, 1'b0, 1'b0);
        // RL A, carry in 1, A=0x80
        regs[7] = 8'h80;
        e = exp_for(8'h17, 8'h80, 1'b1, 0); e.wdata = 8'h01; e.fval = 4'b0001;
        run(e, 1'b1, 1'b0);

`ifdef CB_EXEC_HL_EN
        // SET 3,(HL) with two wait cycles on read and write
        mem_val = 8'h00; mem_delay = 2;
        e = exp_for(8'hDE, 8'h00, 1'b0, 2); e.mwdata = 8'h08;
        run(e, 1'b0, 1'b0);
        // BIT 0,(HL) with start pulsed while busy
        mem_val = 8'h5A; mem_delay = 0;
        e = exp_for(8'h46, 8'h5A, 1'b0, 0); e.fval = 4'b1010;
        run(e, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            op = 8'($urandom); op[2:0] = 3'd6;
            v = 8'($urandom); c = 1'($urandom);
            mem_val = v; mem_delay = int'($urandom_range(0, 2));
            run(exp_for(op, v, c, mem_delay), c, 1'b0);
        end
        mem_delay = 20;
        op = 8'hDE;
`else
        // (HL) rejected: done and illegal at t+1, start pulse ignored
        run(exp_ill(8'h46), 1'b0, 1'b1);
        op = 8'h80;
`endif

        // Reset in the middle of an instruction
        @(posedge clk); #1;
        start = 1'b1; opcode = op;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        chk("reset_mid_outputs", outs(), 64'(0));
        nreset = 1'b1;
        mem_delay = 0;
        @(negedge clk);
        chk("reset_mid_idle", outs(), 64'(0));

        // SET 0,A after reset
        regs[7] = 8'h10;
        e = exp_for(8'hC7, 8'h10, 1'b0, 0); e.wdata = 8'h11;
        run(e, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op = 8'($urandom);
            if (op[2:0] == 3'd6) op[2:0] = 3'd7;
            v = 8'($urandom); c = 1'($urandom);
            regs[op[2:0]] = v;
            run(exp_for(op, v, c, 0), c, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
